// File: rtl/vline_move_ctrl.sv
// Vertical-line motion sequencer: issues one-cycle LD/UP/DW commands to the
// line coordinate counter, bouncing between its limit flags with a dwell at each end.
module vline_move_ctrl #(
  parameter int FRAME_DIV    = 1,
  parameter int PAUSE_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       go,
  input  logic       load_req,
  input  logic       at_max,
  input  logic       at_min,
  output logic       UP,
  output logic       DW,
  output logic       LD,
  output logic       dir,
  output logic [1:0] state,
  output logic [7:0] bounce_cnt
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] MOVE  = 2'b10;
  localparam logic [1:0] DWELL = 2'b11;

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [7:0] PAUSE    = 8'(PAUSE_FRAMES);

  logic [7:0] div;
  logic [7:0] dwell;
  logic       loaded;
  logic       step;
  logic       at_limit;

  always_comb begin
    step     = frame_tick && (div == DIV_LAST);
    // Only the flag facing the current direction matters.
    at_limit = dir ? at_min : at_max;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      UP         <= 1'b0;
      DW         <= 1'b0;
      LD         <= 1'b0;
      dir        <= 1'b0;
      bounce_cnt <= '0;
      div        <= '0;
      dwell      <= '0;
      loaded     <= 1'b0;
    end else begin
      UP <= 1'b0;
      DW <= 1'b0;
      LD <= 1'b0;
      if (state == LOAD) begin
        LD     <= 1'b1;
        loaded <= 1'b1;
        dir    <= 1'b0;
        div    <= '0;
        if (load_req)  state <= LOAD;
        else if (go)   state <= MOVE;
        else           state <= IDLE;
      end else if (load_req) begin
        state <= LOAD;
      end else begin
        case (state)
          IDLE: begin
            if (go) state <= loaded ? MOVE : LOAD;
          end
          MOVE: begin
            if (!go) begin
              state <= IDLE;
              div   <= '0;
            end else if (frame_tick) begin
              if (!step) begin
                div <= div + 8'd1;
              end else begin
                div <= '0;
                if (at_limit) begin
                  dir   <= ~dir;
                  dwell <= PAUSE;
                  state <= DWELL;
                  if (bounce_cnt != '1) bounce_cnt <= bounce_cnt + 8'd1;
                end else if (dir) begin
                  DW <= 1'b1;
                end else begin
                  UP <= 1'b1;
                end
              end
            end
          end
          DWELL: begin
            if (!go) begin
              state <= IDLE;
              dwell <= '0;
            end else if (dwell == '0) begin
              state <= MOVE;
              div   <= '0;
            end else if (frame_tick) begin
              dwell <= dwell - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vline_move_ctrl.sv
// Directed bench for vline_move_ctrl with a cycle-level reference model and
// literal checkpoints for the reset, load, step, dwell, resume and saturation cases.
module tb_vline_move_ctrl;

  localparam int FD = 2;
  localparam int PF = 3;

  logic       clk = 1'b0;
  logic       reset, frame_tick, go, load_req, at_max, at_min;
  logic       UP, DW, LD, dir;
  logic [1:0] state;
  logic [7:0] bounce_cnt;

  int checks = 0;
  int errors = 0;

  vline_move_ctrl #(.FRAME_DIV(FD), .PAUSE_FRAMES(PF)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .go(go),
    .load_req(load_req), .at_max(at_max), .at_min(at_min),
    .UP(UP), .DW(DW), .LD(LD), .dir(dir), .state(state), .bounce_cnt(bounce_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 load, 2 move, 3 dwell.
  int  m_phase, m_frames, m_hold, m_bounces;
  bit  m_up, m_dw, m_ld, m_dir, m_loaded;
  bit  started = 0;

  always @(posedge clk) begin
    int nxt;
    started = 1;
    m_up = 0; m_dw = 0; m_ld = 0;
    if (reset !== 1'b1) begin
      m_phase = 0; m_frames = 0; m_hold = 0; m_bounces = 0;
      m_dir = 0; m_loaded = 0;
    end else begin
      nxt = m_phase;
      if (m_phase == 1) begin
        m_ld = 1; m_loaded = 1; m_dir = 0; m_frames = 0;
        nxt = load_req ? 1 : (go ? 2 : 0);
      end else if (load_req) begin
        nxt = 1;
      end else if (m_phase == 0) begin
        if (go) nxt = m_loaded ? 2 : 1;
      end else if (m_phase == 2) begin
        if (!go) begin
          nxt = 0; m_frames = 0;
        end else if (frame_tick) begin
          m_frames = m_frames + 1;
          if (m_frames == FD) begin
            m_frames = 0;
            if ((m_dir == 0 && at_max) || (m_dir == 1 && at_min)) begin
              m_dir = !m_dir;
              m_bounces = (m_bounces < 255) ? m_bounces + 1 : 255;
              m_hold = PF;
              nxt = 3;
            end else if (m_dir) m_dw = 1;
            else m_up = 1;
          end
        end
      end else begin
        if (!go) begin
          nxt = 0; m_hold = 0;
        end else if (m_hold == 0) begin
          nxt = 2; m_frames = 0;
        end else if (frame_tick) m_hold = m_hold - 1;
      end
      m_phase = nxt;
    end
  end

  int up_seen = 0, dw_seen = 0, ld_seen = 0;

  always @(negedge clk) begin
    if (started) begin
      logic [13:0] act, exp;
      act = {state, UP, DW, LD, dir, bounce_cnt};
      exp = {2'(m_phase), m_up, m_dw, m_ld, m_dir, 8'(m_bounces)};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model t=%0t actual state=%b UP=%b DW=%b LD=%b dir=%b bc=%0d required state=%b UP=%b DW=%b LD=%b dir=%b bc=%0d",
                 $time, state, UP, DW, LD, dir, bounce_cnt,
                 2'(m_phase), m_up, m_dw, m_ld, m_dir, m_bounces);
      end
      if (UP === 1'b1) up_seen++;
      if (DW === 1'b1) dw_seen++;
      if (LD === 1'b1) ld_seen++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ftick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc(); cyc();
    end
  endtask

  int u0, d0, l0;

  initial begin
    reset = 1'b0; go = 1'b1; load_req = 1'b0; at_max = 1'b0; at_min = 1'b0;
    frame_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame_tick = ~frame_tick;
      cyc();
      chk("reset_state", int'(state), 0);
      chk("reset_cmds", int'({UP, DW, LD, dir}), 0);
      chk("reset_bounce", int'(bounce_cnt), 0);
    end
    frame_tick = 1'b0;

    // Release reset: LOAD, then LD with MOVE
    reset = 1'b1;
    cyc();
    chk("enter_load", int'(state), 1);
    chk("ld_not_yet", int'(LD), 0);
    cyc();
    chk("ld_pulse", int'(LD), 1);
    chk("move_after_load", int'(state), 2);
    chk("dir_after_load", int'(dir), 0);
    cyc();
    chk("ld_one_cycle", int'(LD), 0);

    // Six frame ticks with FRAME_DIV=2 -> three UP pulses
    u0 = up_seen; d0 = dw_seen; l0 = ld_seen;
    ftick(6);
    chk("up_count", up_seen - u0, 3);
    chk("no_dw_ld", (dw_seen - d0) + (ld_seen - l0), 0);

    // Upper limit on a step tick -> bounce into dwell
    at_max = 1'b1;
    u0 = up_seen;
    ftick(2);
    chk("no_up_at_max", up_seen - u0, 0);
    chk("dwell_state", int'(state), 3);
    chk("dir_reversed", int'(dir), 1);
    chk("bounce_one", int'(bounce_cnt), 1);
    at_max = 1'b0;
    ftick(2);
    chk("still_dwell", int'(state), 3);
    ftick(1);
    chk("dwell_done", int'(state), 2);
    d0 = dw_seen;
    ftick(2);
    chk("dw_after_dwell", dw_seen - d0, 1);

    // Bounce off min, then off max again so dir=1 in dwell
    at_min = 1'b1;
    ftick(2);
    chk("bounce_min", int'(bounce_cnt), 2);
    chk("dir_up_again", int'(dir), 0);
    at_min = 1'b0;
    ftick(3);
    at_max = 1'b1;
    ftick(2);
    at_max = 1'b0;
    chk("dwell_again", int'(state), 3);
    ftick(1);

    // Drop go mid-dwell, then resume without reload
    u0 = up_seen; d0 = dw_seen; l0 = ld_seen;
    go = 1'b0;
    cyc();
    chk("idle_from_dwell", int'(state), 0);
    cyc();
    go = 1'b1;
    cyc();
    chk("resume_move", int'(state), 2);
    chk("resume_dir", int'(dir), 1);
    cyc();
    chk("resume_no_cmd", (up_seen - u0) + (dw_seen - d0) + (ld_seen - l0), 0);

    // load_req coinciding with a step tick
    ftick(1);
    u0 = up_seen; d0 = dw_seen; l0 = ld_seen;
    load_req = 1'b1; frame_tick = 1'b1;
    cyc();
    load_req = 1'b0; frame_tick = 1'b0;
    chk("load_preempts", int'(state), 1);
    cyc();
    chk("ld_on_req", int'(LD), 1);
    chk("dir_reset_by_load", int'(dir), 0);
    cyc();
    chk("only_ld", (up_seen - u0) + (dw_seen - d0), 0);
    chk("ld_once", ld_seen - l0, 1);

    // Continuous bouncing: counter saturates at 255
    at_max = 1'b1; at_min = 1'b1; frame_tick = 1'b1;
    repeat (2000) cyc();
    frame_tick = 1'b0; at_max = 1'b0; at_min = 1'b0;
    chk("bounce_saturate", int'(bounce_cnt), 255);

    // Reset mid-operation forces a fresh LOAD
    reset = 1'b0;
    cyc();
    chk("midreset_idle", int'(state), 0);
    reset = 1'b1;
    cyc();
    chk("fresh_load", int'(state), 1);
    cyc();
    chk("fresh_ld", int'(LD), 1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vline_move_ctrl.md
Name: vline_move_ctrl

Overview:
Sequencer for the vertical-line position counter of the Wild Cube game. Once per video frame it issues single-cycle load, step-up and step-down commands to the 16-bit line coordinate counter. It reads that counter's upper and lower limit flags and bounces the line between them, holding for a programmable number of frames at each end. It sits between the VGA frame timing and the line-move counter, replacing direct button control of UP/DW/LD.

Parameters:
FRAME_DIV, 1, frame_ticks per position step (legal range 1..255)
PAUSE_FRAMES, 30, frame_ticks held at each limit before reversing (legal range 0..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
frame_tick  in  1  single-cycle pulse once per video frame
go  in  1  level; 1 = motion enabled
load_req  in  1  single-cycle request to reload the start position
at_max  in  1  counter upper-limit flag (Y == 487)
at_min  in  1  counter lower-limit flag (Y == 18)
UP  out  1  one-cycle step-up command to counter
DW  out  1  one-cycle step-down command to counter
LD  out  1  one-cycle load command to counter
dir  out  1  0 = increasing Y, 1 = decreasing Y
state  out  2  IDLE=00, LOAD=01, MOVE=10, DWELL=11
bounce_cnt  out  8  direction reversals since reset, saturating at 255

Behaviour:
- All state updates happen on rising clk. reset=0 has priority over every other input. During reset: state=IDLE, UP=DW=LD=0, dir=0, bounce_cnt=0, frame divider=0, dwell counter=0, internal loaded flag=0.
- UP, DW and LD are registered and mutually exclusive. Each is high for exactly one cycle, and only in the cycle after the decision.
- load_req=1 in any state: next state is LOAD. This takes priority over go, frame_tick and the limit flags.
- IDLE:
  - If go=1 and loaded=0: go to LOAD.
  - If go=1 and loaded=1: go to MOVE (resume; no LD; dir kept).
  - Otherwise stay in IDLE.
- LOAD (one cycle):
  - LD=1 in the cycle after entering LOAD.
  - Set loaded=1, dir=0, divider=0.
  - Next state is MOVE if go=1, else IDLE.
- MOVE:
  - go=0: go to IDLE next cycle, divider cleared, no command issued.
  - On frame_tick with divider < FRAME_DIV-1: divider increments.
  - On frame_tick with divider == FRAME_DIV-1: divider returns to 0 and this is a step tick.
  - On a step tick, dir=0, at_max=0: UP pulse.
  - On a step tick, dir=1, at_min=0: DW pulse.
  - On a step tick where the current-direction flag is 1: no pulse, dir toggles, bounce_cnt increments (saturating), dwell counter = PAUSE_FRAMES, go to DWELL.
  - If both at_max and at_min are 1, only the flag for the current direction is used.
- DWELL:
  - go=0: go to IDLE, dwell counter cleared.
  - If dwell counter == 0: go to MOVE next cycle, so PAUSE_FRAMES=0 costs one clock.
  - Otherwise each frame_tick decrements the counter. The cycle after it reaches 0, go to MOVE with divider=0.
- Latency: frame_tick at cycle n that is a step tick gives UP/DW high at cycle n+1 only. The counter's flags are sampled only at frame_tick, long after the previous step has settled.
- At most one command per frame_tick. No command ever fires in IDLE or DWELL.
- Reset asserted mid-operation: the state is lost and the next go forces a fresh LOAD.

Test Plan:
1. Hold reset=0 for 3 cycles with go=1 and frame_ticks -> state=00, UP=DW=LD=0, dir=0, bounce_cnt=0 throughout.
2. Release reset with go=1 -> LOAD entered in the first cycle, LD=1 for exactly one cycle, then state=10, dir=0.
3. FRAME_DIV=2, at_max=0, 6 frame_ticks -> exactly 3 UP pulses, one cycle after the 2nd, 4th and 6th ticks; DW=LD=0.
4. PAUSE_FRAMES=3, at_max=1 on a step tick:
   - No UP; dir=1, bounce_cnt=1, state=11.
   - After 3 frame_ticks, state=10.
   - The next step tick with at_min=0 gives DW=1.
5. Drop go mid-DWELL -> state=00 next cycle, no pulses. Reassert go -> state=10 with no LD and dir still 1.
6. load_req in the same cycle as a step tick in MOVE -> LD only (no UP), dir=0. Force 300 bounces -> bounce_cnt holds at 255.
